// File: rtl/telemetry_pkg.sv
// Shared state type, ASCII constants and hex formatting for the angle telemetry transmitter.
// Build option: define TX_PARITY_EN to add an even-parity bit to every byte.
package telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SEND_BYTE = 2'd2,
    NEXT      = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  localparam int FRAME_LEN  = 15;
  localparam int HEX_DIGITS = 6;
  localparam logic [3:0] LAST_BYTE_IDX = 4'(FRAME_LEN - 1);

`ifdef TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'b0000, nib};
    else return ASCII_A + {4'b0000, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as start / 8 data LSB first / [even parity] / stop, CLKS_PER_BIT cycles per bit.
// Build option: TX_PARITY_EN adds the parity bit. A load in the final stop cycle chains bytes gaplessly.
module uart_tx_byte
  import telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_byte_done
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT   = 4'(BITS_PER_BYTE - 1);

  logic                     r_active;
  logic [BITS_PER_BYTE-1:0] r_shift;
  logic [3:0]               r_bit_idx;
  logic [15:0]              r_bit_cnt;
  logic [BITS_PER_BYTE-1:0] w_frame;
  logic                     w_bit_end;

`ifdef TX_PARITY_EN
  assign w_frame = {1'b1, ^i_data, i_data, 1'b0};
`else
  assign w_frame = {1'b1, i_data, 1'b0};
`endif

  assign w_bit_end   = r_active && (r_bit_cnt == 16'd0);
  assign o_byte_done = w_bit_end && (r_bit_idx == LAST_BIT);
  assign o_tx        = r_active ? r_shift[0] : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_shift   <= '0;
      r_bit_idx <= 4'd0;
      r_bit_cnt <= 16'd0;
    end else if (i_load) begin
      r_active  <= 1'b1;
      r_shift   <= w_frame;
      r_bit_idx <= 4'd0;
      r_bit_cnt <= BIT_RELOAD;
    end else if (w_bit_end) begin
      r_bit_cnt <= BIT_RELOAD;
      r_shift   <= {1'b1, r_shift[BITS_PER_BYTE-1:1]};
      if (r_bit_idx == LAST_BIT) begin
        r_active  <= 1'b0;
        r_bit_idx <= 4'd0;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
      end
    end else if (r_active) begin
      r_bit_cnt <= r_bit_cnt - 16'd1;
    end
  end

endmodule

// File: rtl/angle_telemetry_tx.sv
// Sends "S<6 hex shoulder>E<6 hex elbow>\n" over UART on each accepted start; frame FSM and hex formatter.
// Build option: TX_PARITY_EN (even parity per byte, 11 bits per byte instead of 10).
module angle_telemetry_tx
  import telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] shoulder_angle,
  input  logic [23:0] elbow_angle,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output state_e      o_dbg_state
);

  state_e      r_state;
  state_e      w_next_state;
  logic [3:0]  r_byte_idx;
  logic [23:0] r_shoulder;
  logic [23:0] r_elbow;
  logic        w_frame_end;
  logic        w_accept;
  logic        w_load;
  logic        w_byte_done;
  logic [3:0]  w_load_idx;
  logic [7:0]  w_load_data;
  logic [23:0] w_word;
  logic [2:0]  w_digit;
  logic [4:0]  w_shamt;
  logic [3:0]  w_nibble;

  // NEXT at the last index is the done cycle; it behaves like IDLE for accepting start.
  assign w_frame_end = (r_state == NEXT) && (r_byte_idx == LAST_BYTE_IDX);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (start) w_next_state = LOAD;
      LOAD:      w_next_state = SEND_BYTE;
      SEND_BYTE: if (w_byte_done) w_next_state = NEXT;
      NEXT: begin
        if (r_byte_idx < LAST_BYTE_IDX) w_next_state = SEND_BYTE;
        else if (start)                 w_next_state = LOAD;
        else                            w_next_state = IDLE;
      end
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = !((r_state == IDLE) || w_frame_end);
    done       = w_frame_end;
    w_accept   = start && ((r_state == IDLE) || w_frame_end);
    w_load     = w_accept ||
                 ((r_state == SEND_BYTE) && w_byte_done && (r_byte_idx < LAST_BYTE_IDX));
    w_load_idx = w_accept ? 4'd0 : r_byte_idx + 4'd1;
  end

  // Byte 0 is the constant 'S', so the accepting edge can load it before the angles are latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shoulder <= 24'd0;
      r_elbow    <= 24'd0;
      r_byte_idx <= 4'd0;
    end else begin
      if (w_accept) begin
        r_shoulder <= shoulder_angle;
        r_elbow    <= elbow_angle;
      end
      if (r_state == LOAD)
        r_byte_idx <= 4'd0;
      else if ((r_state == NEXT) && (r_byte_idx < LAST_BYTE_IDX))
        r_byte_idx <= r_byte_idx + 4'd1;
    end
  end

  assign w_word   = (w_load_idx <= 4'(HEX_DIGITS)) ? r_shoulder : r_elbow;
  assign w_digit  = (w_load_idx <= 4'(HEX_DIGITS)) ? 3'(w_load_idx - 4'd1)
                                                   : 3'(w_load_idx - 4'(HEX_DIGITS + 2));
  assign w_shamt  = 5'd20 - {w_digit, 2'b00};
  assign w_nibble = 4'(w_word >> w_shamt);

  always_comb begin
    w_load_data = ASCII_LF;
    if (w_load_idx == 4'd0)                        w_load_data = ASCII_S;
    else if (w_load_idx <= 4'(HEX_DIGITS))         w_load_data = hex_ascii(w_nibble);
    else if (w_load_idx == 4'(HEX_DIGITS + 1))     w_load_data = ASCII_E;
    else if (w_load_idx <= 4'(2 * HEX_DIGITS + 1)) w_load_data = hex_ascii(w_nibble);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .o_tx       (tx),
    .o_byte_done(w_byte_done)
  );

endmodule
